inv_mix_cols: RTL and testbench

INV_MIX_COLS -- requirements
Module: inv_mix_cols

---
 rtl/inv_mix_cols_if.sv | 33 +++
 rtl/inv_mix_cols.sv | 136 +++++++++++++
 tb/tb_inv_mix_cols.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_mix_cols_if.sv
// Purpose: request/result bundle for the inverse MixColumns engine.
// Latency: none, signals only.
// Backpressure: a requester may only rely on start being taken while ready_out is high.
//
// Signals:
//   start      - request strobe, block_in offered in the same cycle
//   block_in   - 128-bit block, byte (row r, col c) at [32*r+8*c +: 8]
//   ready_out  - engine idle, a start will be accepted
//   result_out - last completed inverse-mixed block
//   valid_out  - one-cycle pulse marking a new result_out
interface inv_mix_cols_if;
  logic         start;
  logic [127:0] block_in;
  logic         ready_out;
  logic [127:0] result_out;
  logic         valid_out;

  modport master (
    output start,
    output block_in,
    input  ready_out,
    input  result_out,
    input  valid_out
  );

  modport slave (
    input  start,
    input  block_in,
    output ready_out,
    output result_out,
    output valid_out
  );
endinterface

// File: rtl/inv_mix_cols.sv
// Purpose: AES inverse MixColumns over a 128-bit block, IDLE -> COMPUTE -> OUTPUT FSM.
// Latency: valid_out in the 5th cycle after the start edge (2nd when INV_MIX_COLS_FAST_EN is defined).
// Backpressure: start is taken only in IDLE (ready_out high); it is ignored otherwise, nothing queues.
//
// Ports:
//   clk_in - single clock, rising edge
//   rst_in - synchronous active-low reset
//   bus    - inv_mix_cols_if.slave (start/block_in in, ready_out/result_out/valid_out out)
// Build option: define INV_MIX_COLS_FAST_EN to compute all four columns in one COMPUTE cycle;
// otherwise one column is processed per cycle through an internal accumulator.
module inv_mix_cols (
  input  logic          clk_in,
  input  logic          rst_in,
  inv_mix_cols_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  state_t       r_state;
  logic [127:0] r_blk;
  logic [127:0] r_result;
  logic         r_valid;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] f_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // All inverse coefficients (0e, 0b, 0d, 09) fit in 4 bits, so a product is the
  // XOR of the selected a*1, a*2, a*4, a*8 terms.
  function automatic logic [7:0] f_gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = f_xt(a);
    x4 = f_xt(x2);
    x8 = f_xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  // Gather column c as {s3,s2,s1,s0}.
  function automatic logic [31:0] f_get_col(input logic [127:0] blk, input int c);
    logic [31:0] col;
    for (int r = 0; r < 4; r++) begin
      col[8*r +: 8] = blk[32*r + 8*c +: 8];
    end
    return col;
  endfunction

  // Output byte r of one inverse-mixed column.
  function automatic logic [7:0] f_inv_byte(input logic [31:0] col, input int r);
    return f_gm(col[8*r +: 8], 4'he) ^
           f_gm(col[8*((r + 1) % 4) +: 8], 4'hb) ^
           f_gm(col[8*((r + 2) % 4) +: 8], 4'hd) ^
           f_gm(col[8*((r + 3) % 4) +: 8], 4'h9);
  endfunction

`ifdef INV_MIX_COLS_FAST_EN
  logic [127:0] w_full;

  always_comb begin
    w_full = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_full[32*r + 8*c +: 8] = f_inv_byte(f_get_col(r_blk, c), r);
      end
    end
  end
`else
  logic [1:0]   r_col;
  logic [127:0] r_acc;
  logic [31:0]  w_col;
  logic [127:0] w_acc_next;

  // Accumulator with the current column's result merged in; at column 3 this is the
  // complete block, so it can be published directly without an extra cycle.
  always_comb begin
    w_col      = f_get_col(r_blk, int'(r_col));
    w_acc_next = r_acc;
    for (int r = 0; r < 4; r++) begin
      w_acc_next[32*r + 8*int'(r_col) +: 8] = f_inv_byte(w_col, r);
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_valid  <= 1'b0;
`ifndef INV_MIX_COLS_FAST_EN
      r_col    <= 2'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_blk   <= bus.block_in;
            r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
`ifdef INV_MIX_COLS_FAST_EN
          r_result <= w_full;
          r_valid  <= 1'b1;
          r_state  <= S_OUTPUT;
`else
          r_acc <= w_acc_next;
          r_col <= r_col + 2'd1;  // wraps 3 -> 0 on exit
          if (r_col == 2'd3) begin
            r_result <= w_acc_next;
            r_valid  <= 1'b1;
            r_state  <= S_OUTPUT;
          end
`endif
        end
        S_OUTPUT: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready_out  = (r_state == S_IDLE);
  assign bus.result_out = r_result;
  assign bus.valid_out  = r_valid;

endmodule

// File: tb/tb_inv_mix_cols.sv
// Purpose: self-checking bench for inv_mix_cols against a GF(2^8) matrix model.
// Latency: expects valid 5 cycles after the start edge (2 with INV_MIX_COLS_FAST_EN).
// Backpressure: starts are only counted as accepted when ready_out was high.
module tb_inv_mix_cols;

`ifdef INV_MIX_COLS_FAST_EN
  localparam int LAT      = 2;
  localparam int INTERVAL = 3;
  localparam int RST_OFF  = 1;
`else
  localparam int LAT      = 5;
  localparam int INTERVAL = 6;
  localparam int RST_OFF  = 3;
`endif

  logic clk = 1'b0;
  logic rst_in;

  inv_mix_cols_if bus ();

  inv_mix_cols dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: polynomial product then reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ ({8'h00, a} << i);
    end
    for (int i = 15; i >= 8; i--) begin
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    end
    return p[7:0];
  endfunction

  // Circulant column mix: out[r] = sum_j k[j] * s[(r+j) mod 4].
  function automatic logic [127:0] mix_model(input logic [127:0] blk, input logic [7:0] k0,
                                             input logic [7:0] k1, input logic [7:0] k2,
                                             input logic [7:0] k3);
    logic [7:0]   k[4];
    logic [7:0]   s[4];
    logic [7:0]   acc;
    logic [127:0] res;
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) s[r] = blk[32*r + 8*c +: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(k[j], s[(r + j) % 4]);
        res[32*r + 8*c +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] blk);
    return mix_model(blk, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] fwd_model(input logic [127:0] blk);
    return mix_model(blk, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    logic [127:0] blk;
    int           edge_i;
  } acc_t;

  acc_t         q[$];
  acc_t         mon_e;
  int           cyc      = 0;
  logic         prev_rdy = 1'b0;
  logic         prev_vld = 1'b0;
  logic [127:0] last_res = '0;
  int           n_valid  = 0;
  bit           b2b_on   = 1'b0;
  int           b2b_last = -1;

  always @(posedge clk) cyc++;

  // Inputs change only #1 after a falling edge, so values seen here are the ones the
  // preceding rising edge sampled; prev_rdy is the state that edge started from.
  always @(negedge clk) begin
    if (!rst_in) begin
      q.delete();
      check("rst_result", bus.result_out, 128'h0);
      check("rst_valid", {127'h0, bus.valid_out}, 128'h0);
      check("rst_ready", {127'h0, bus.ready_out}, 128'h1);
      last_res = '0;
    end else begin
      if (bus.start && prev_rdy) q.push_back('{bus.block_in, cyc});
      if (bus.valid_out) begin
        n_valid++;
        check("valid_one_cycle", {127'h0, prev_vld}, 128'h0);
        check("sb_pending", {127'h0, (q.size() != 0)}, 128'h1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("sb_result", bus.result_out, inv_model(mon_e.blk));
          check("sb_latency", 128'(cyc - mon_e.edge_i), 128'(LAT - 1));
        end
        if (b2b_on) begin
          if (b2b_last >= 0) check("b2b_interval", 128'(cyc - b2b_last), 128'(INTERVAL));
          b2b_last = cyc;
        end
        last_res = bus.result_out;
      end else begin
        check("result_stable", bus.result_out, last_res);
      end
    end
    prev_rdy = bus.ready_out;
    prev_vld = bus.valid_out;
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic s, input logic [127:0] b, input logic r);
    @(negedge clk);
    #1;
    bus.start    = s;
    bus.block_in = b;
    rst_in       = r;
  endtask

  task automatic run_one(input logic [127:0] b, input logic [127:0] exp, input string tag);
    bit got_rdy;
    int lat;
    got_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ready_out) begin
        got_rdy = 1'b1;
        break;
      end
    end
    check({tag, "_ready"}, {127'h0, got_rdy}, 128'h1);
    if (!got_rdy) return;
    #1;
    bus.start    = 1'b1;
    bus.block_in = b;
    rst_in       = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.valid_out) begin
        lat = i;
        break;
      end
      if (i == 1) begin
        #1;
        bus.start    = 1'b0;
        bus.block_in = rnd();
      end
    end
    if (bus.start) begin
      #1;
      bus.start = 1'b0;
    end
    check({tag, "_lat"}, 128'(lat), 128'(LAT));
    check({tag, "_res"}, bus.result_out, exp);
  endtask

  int           nb;
  logic [127:0] x;

  initial begin
    rst_in       = 1'b0;
    bus.start    = 1'b0;
    bus.block_in = '0;

    // Reset, with a start offered under reset that must be dropped.
    step(1'b0, '0, 1'b0);
    step(1'b1, rnd(), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    check("ready_after_release", {127'h0, bus.ready_out}, 128'h1);
    check("valid_after_release", {127'h0, bus.valid_out}, 128'h0);
    check("result_after_release", bus.result_out, 128'h0);

    // Known vectors.
    run_one(128'hbcbcbcbc_a1a1a1a1_4d4d4d4d_8e8e8e8e,
            128'h45454545_53535353_13131313_dbdbdbdb, "kat_same_cols");
    run_one(128'hc6019dbc_c60158a1_c601dc4d_c6019f8e,
            128'hc6015c45_c6012253_c6010a13_c601f2db, "kat_distinct_cols");
    run_one({128{1'b1}}, {128{1'b1}}, "kat_all_ones");

    // start held high with block_in changing every cycle.
    repeat (4) step(1'b0, '0, 1'b1);
    nb       = n_valid;
    b2b_last = -1;
    b2b_on   = 1'b1;
    repeat (8 * INTERVAL) step(1'b1, rnd(), 1'b1);
    repeat (10) step(1'b0, rnd(), 1'b1);
    b2b_on = 1'b0;
    check("b2b_count", 128'(n_valid - nb), 128'd8);

    // Reset while a block is in flight, then reset again with start asserted.
    step(1'b1, rnd(), 1'b1);
    repeat (RST_OFF - 1) step(1'b0, rnd(), 1'b1);
    nb = n_valid;
    step(1'b0, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b0);
    step(1'b0, rnd(), 1'b1);
    @(negedge clk);
    check("ready_after_midrst", {127'h0, bus.ready_out}, 128'h1);
    check("result_after_midrst", bus.result_out, 128'h0);
    repeat (12) step(1'b0, rnd(), 1'b1);
    check("no_pulse_after_rst", 128'(n_valid - nb), 128'd0);
    x = rnd();
    run_one(x, inv_model(x), "fresh_after_rst");

    // Round trip through the forward mix.
    for (int i = 0; i < 1000; i++) begin
      x = rnd();
      run_one(fwd_model(x), x, "roundtrip");
      repeat ($urandom_range(0, 2)) step(1'b0, rnd(), 1'b1);
    end

    repeat (8) step(1'b0, '0, 1'b1);
    check("sb_drained", 128'(q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
